// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the TX framer and the RX checker.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, PAY, PAD, FCS, IFG, DRAIN
  } eth_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  // Reflected CRC-32 advanced by one byte, data bits consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Running IEEE 802.3 CRC register; fcs is the complemented value sent on the wire.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        frz,
  input  logic [7:0]  data,
  output logic [31:0] fcs
);

  logic [31:0] crc;

  // Clear wins over update; freeze holds the value while the FCS is shifted out.
  always_ff @(posedge clk) begin
    if (!rst_n || clr)  crc <= CRC_INIT;
    else if (en && !frz) crc <= crc32_byte(crc, data);
  end

  assign fcs = ~crc;

endmodule

// File: rtl/axis_eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble, SFD, payload, pad, FCS, inter-frame gap.
module axis_eth_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 60,
  parameter int MAX_PAYLOAD    = 1514,
  parameter int IFG_BYTES      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  output logic       s_axis_tready,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       tx_err,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam int            CW       = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_PAYLOAD);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_PAYLOAD);
  localparam logic [3:0]    PRE_LAST = 4'(PREAMBLE_BYTES - 1);
  localparam logic [3:0]    IFG_LAST = 4'(IFG_BYTES - 1);

  eth_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [3:0]    sc, sc_nx;          // preamble / FCS / IFG byte index
  logic          done_nx, abort_nx;
  logic          crc_clr, crc_en, crc_frz;
  logic [7:0]    crc_d;
  logic [31:0]   fcs;

  assign cnt_inc = cnt + CW'(1);
  assign busy    = (state != IDLE);

  eth_crc32 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .frz   (crc_frz),
    .data  (crc_d),
    .fcs   (fcs)
  );

  // State, counters and the registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sc          <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sc          <= sc_nx;
      frame_done  <= done_nx;
      frame_abort <= abort_nx;
    end
  end

  // Next state and outputs; everything advances only on tx_ready byte-times.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    sc_nx         = sc;
    tx_en         = 1'b0;
    tx_data       = 8'h00;
    tx_err        = 1'b0;
    s_axis_tready = 1'b0;
    done_nx       = 1'b0;
    abort_nx      = 1'b0;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    crc_frz       = 1'b0;
    crc_d         = s_axis_tdata;
    case (state)
      IDLE: begin
        crc_clr = 1'b1;
        cnt_nx  = '0;
        sc_nx   = '0;
        if (s_axis_tvalid) state_nx = PRE;
      end
      PRE: begin
        tx_en   = 1'b1;
        tx_data = ETH_PREAMBLE;
        if (tx_ready) begin
          if (sc == PRE_LAST) begin
            sc_nx    = '0;
            state_nx = SFD;
          end else begin
            sc_nx = sc + 4'd1;
          end
        end
      end
      SFD: begin
        tx_en   = 1'b1;
        tx_data = ETH_SFD;
        if (tx_ready) state_nx = PAY;
      end
      PAY: begin
        tx_en         = 1'b1;
        tx_data       = s_axis_tdata;
        s_axis_tready = tx_ready & s_axis_tvalid;
        if (tx_ready && !s_axis_tvalid) begin
          // Underrun: burn this byte-time as a poisoned byte and drop the frame.
          tx_err   = 1'b1;
          tx_data  = 8'h00;
          abort_nx = 1'b1;
          state_nx = DRAIN;
        end else if (tx_ready) begin
          crc_en = 1'b1;
          cnt_nx = cnt_inc;
          if (cnt == MAX_C) begin
            // One byte past the limit; if it happens to be the last, nothing remains to drain.
            tx_err   = 1'b1;
            abort_nx = 1'b1;
            state_nx = s_axis_tlast ? IFG : DRAIN;
          end else if (s_axis_tlast) begin
            state_nx = (cnt_inc < MIN_C) ? PAD : FCS;
          end
        end
      end
      PAD: begin
        tx_en   = 1'b1;
        crc_d   = 8'h00;
        if (tx_ready) begin
          crc_en = 1'b1;
          cnt_nx = cnt_inc;
          if (cnt_inc == MIN_C) state_nx = FCS;
        end
      end
      FCS: begin
        tx_en   = 1'b1;
        crc_frz = 1'b1;
        tx_data = fcs[{sc[1:0], 3'b000} +: 8];
        if (tx_ready) begin
          if (sc == 4'd3) begin
            sc_nx    = '0;
            done_nx  = 1'b1;
            state_nx = IFG;
          end else begin
            sc_nx = sc + 4'd1;
          end
        end
      end
      IFG: begin
        if (tx_ready) begin
          if (sc == IFG_LAST) begin
            sc_nx    = '0;
            state_nx = IDLE;
          end else begin
            sc_nx = sc + 4'd1;
          end
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nx = IFG;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_eth_tx_framer.sv
// Scoreboard bench: expected PHY bytes are queued as frames are offered, popped as the DUT emits them.
module tb_axis_eth_tx_framer;

  typedef struct packed {
    logic [7:0] d;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_ready;
  logic [7:0] tdata [2];
  logic       tvalid[2], tlast[2], tready[2];
  logic [7:0] txd   [2];
  logic       txen[2], txerr[2], busy[2], done[2], abrt[2];

  // Instance 0 has no minimum length (unpadded check frame); instance 1 uses defaults.
  axis_eth_tx_framer #(.MIN_PAYLOAD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tlast(tlast[0]),
    .s_axis_tready(tready[0]),
    .tx_data(txd[0]), .tx_en(txen[0]), .tx_err(txerr[0]), .tx_ready(tx_ready),
    .busy(busy[0]), .frame_done(done[0]), .frame_abort(abrt[0])
  );

  axis_eth_tx_framer u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tlast(tlast[1]),
    .s_axis_tready(tready[1]),
    .tx_data(txd[1]), .tx_en(txen[1]), .tx_err(txerr[1]), .tx_ready(tx_ready),
    .busy(busy[1]), .frame_done(done[1]), .frame_abort(abrt[1])
  );

  int   vectors = 0, miscompares = 0;
  exp_t q0[$], q1[$];
  int   xfers[2], dones[2], aborts[2], gap[2], idle_run[2];
  logic chk_rdy = 1'b0;
  logic [7:0] pl [0:1599];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Bit-serial reference CRC.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic push_exp(input int s, input logic [7:0] d, input logic err);
    exp_t x;
    x.d = d; x.err = err;
    if (s == 0) q0.push_back(x); else q1.push_back(x);
  endtask

  task automatic push_head(input int s, input int k);
    for (int i = 0; i < 7; i++) push_exp(s, 8'h55, 1'b0);
    push_exp(s, 8'hD5, 1'b0);
    for (int i = 0; i < k; i++) push_exp(s, pl[i], 1'b0);
  endtask

  task automatic push_frame(input int s, input int len, input int minp);
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    push_head(s, len);
    for (int i = 0; i < len; i++) c = crc_ref(c, pl[i]);
    for (n = len; n < minp; n++) begin
      push_exp(s, 8'h00, 1'b0);
      c = crc_ref(c, 8'h00);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) push_exp(s, c[8*k +: 8], 1'b0);
  endtask

  // Offer pl[0..len-1] as one frame; stop after stop_after accepts; optional one-strobe valid gap.
  task automatic send(input int s, input int len, input int stop_after, input int gap_at, input int rdy_div);
    int i, cyc;
    bit gdone, acc;
    i = 0; cyc = 0; gdone = 0;
    while (i < stop_after && cyc < 20000) begin
      tx_ready = ((cyc % rdy_div) == 0);
      if (i == gap_at && !gdone) begin
        tvalid[s] = 1'b0;
      end else begin
        tvalid[s] = 1'b1;
        tdata[s]  = pl[i];
        tlast[s]  = (i == len - 1);
      end
      @(negedge clk);
      acc = tvalid[s] & tready[s];
      if (!tvalid[s] && tx_ready) gdone = 1;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    chk("send_complete", i, stop_after);
    tvalid[s] = 1'b0;
    tlast[s]  = 1'b0;
    tx_ready  = 1'b1;
  endtask

  task automatic wait_q(input int s, input int budget);
    int n;
    n = 0;
    while (((s == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("sb_drained", (s == 0) ? q0.size() : q1.size(), 0);
  endtask

  task automatic wait_idle(input int s, input int budget);
    int n;
    n = 0;
    while (busy[s] !== 1'b0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("back_to_idle", busy[s], 1'b0);
  endtask

  // Monitor: every PHY transfer must match the head of that instance's scoreboard.
  exp_t mx;
  logic got;
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (done[s] === 1'b1) dones[s]++;
      if (abrt[s] === 1'b1) aborts[s]++;
      if (txen[s] === 1'b1) begin
        if (idle_run[s] != 0) gap[s] = idle_run[s];
        idle_run[s] = 0;
      end else begin
        idle_run[s]++;
      end
      if (txen[s] === 1'b1 && tx_ready === 1'b1) begin
        xfers[s]++;
        got = 1'b0;
        if (s == 0 && q0.size() > 0) begin mx = q0.pop_front(); got = 1'b1; end
        if (s == 1 && q1.size() > 0) begin mx = q1.pop_front(); got = 1'b1; end
        chk("sb_has_entry", got, 1'b1);
        if (got) begin
          chk("tx_data", txd[s], mx.d);
          chk("tx_err", txerr[s], mx.err);
        end
      end
    end
    if (chk_rdy) chk("tready_only_on_strobe", tready[1] & ~tx_ready, 1'b0);
  end

  int d0, a0, x0;

  initial begin
    for (int s = 0; s < 2; s++) begin
      xfers[s] = 0; dones[s] = 0; aborts[s] = 0; gap[s] = 0; idle_run[s] = 0;
      tdata[s] = 8'h00; tvalid[s] = 1'b0; tlast[s] = 1'b0;
    end
    rst_n = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx_en", txen[s], 1'b0);
      chk("rst_tx_err", txerr[s], 1'b0);
      chk("rst_busy", busy[s], 1'b0);
      chk("rst_tready", tready[s], 1'b0);
      chk("rst_done", done[s], 1'b0);
      chk("rst_abort", abrt[s], 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; tx_ready = 1'b1;

    // Check frame "123456789", known FCS, then a second frame to measure the gap.
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    d0 = dones[0];
    push_head(0, 9);
    push_exp(0, 8'h26, 1'b0); push_exp(0, 8'h39, 1'b0);
    push_exp(0, 8'hF4, 1'b0); push_exp(0, 8'hCB, 1'b0);
    send(0, 9, 9, -1, 1);
    push_frame(0, 9, 0);
    send(0, 9, 9, -1, 1);
    wait_q(0, 200);
    wait_idle(0, 100);
    chk("t1_done_count", dones[0] - d0, 2);
    chk("t1_ifg_gap", (gap[0] >= 12 && gap[0] <= 13), 1'b1);

    // 20-byte frame padded to 60.
    for (int i = 0; i < 20; i++) pl[i] = 8'(i);
    d0 = dones[1]; x0 = xfers[1];
    push_frame(1, 20, 60);
    send(1, 20, 20, -1, 1);
    wait_q(1, 200);
    wait_idle(1, 100);
    chk("t2_xfers", xfers[1] - x0, 72);
    chk("t2_done_count", dones[1] - d0, 1);

    // 60-byte frame, PHY strobes one cycle in four.
    for (int i = 0; i < 60; i++) pl[i] = 8'(i * 7 + 3);
    d0 = dones[1];
    push_frame(1, 60, 60);
    chk_rdy = 1'b1;
    send(1, 60, 60, -1, 4);
    chk_rdy = 1'b0;
    wait_q(1, 200);
    wait_idle(1, 100);
    chk("t3_done_count", dones[1] - d0, 1);

    // Underrun after byte 10 of a 30-byte frame, then a clean frame.
    for (int i = 0; i < 30; i++) pl[i] = 8'hA0 + 8'(i);
    d0 = dones[1]; a0 = aborts[1];
    push_head(1, 10);
    push_exp(1, 8'h00, 1'b1);
    send(1, 30, 30, 10, 1);
    wait_q(1, 100);
    wait_idle(1, 100);
    chk("t4_abort_count", aborts[1] - a0, 1);
    chk("t4_no_done", dones[1] - d0, 0);
    for (int i = 0; i < 20; i++) pl[i] = 8'hC3 ^ 8'(i);
    push_frame(1, 20, 60);
    send(1, 20, 20, -1, 1);
    wait_q(1, 200);
    wait_idle(1, 100);
    chk("t4_next_done", dones[1] - d0, 1);

    // Oversize: 1515 bytes, the last one is flagged and no FCS follows.
    for (int i = 0; i < 1515; i++) pl[i] = 8'(i) ^ 8'h5A;
    d0 = dones[1]; a0 = aborts[1];
    push_head(1, 1514);
    push_exp(1, pl[1514], 1'b1);
    send(1, 1515, 1515, -1, 1);
    wait_q(1, 100);
    wait_idle(1, 100);
    chk("t5_abort_count", aborts[1] - a0, 1);
    chk("t5_no_done", dones[1] - d0, 0);

    // Reset mid-payload, then a fresh frame.
    for (int i = 0; i < 60; i++) pl[i] = 8'(i * 3);
    push_head(1, 20);
    send(1, 60, 20, -1, 1);
    tx_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tvalid[1] = 1'b1; tdata[1] = pl[0]; tlast[1] = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("t6_tx_en_after_rst", txen[1], 1'b0);
    chk("t6_busy_after_rst", busy[1], 1'b0);
    chk("t6_tready_after_rst", tready[1], 1'b0);
    @(posedge clk); #1;
    wait_q(1, 10);
    d0 = dones[1];
    push_frame(1, 60, 60);
    send(1, 60, 60, -1, 1);
    wait_q(1, 200);
    wait_idle(1, 100);
    chk("t6_done_count", dones[1] - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
